// File: rtl/req_join_ctrl.sv
// Four-phase request join: collects reqNumber requests, fires one joined fin, then drains acks.
// Optional COLLECT timeout abort enabled by defining REQ_JOIN_TIMEOUT_EN.
module req_join_ctrl #(
    parameter int reqNumber      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [reqNumber-1:0]               reqs,
    output logic [reqNumber-1:0]               acks,
    output logic                               fin,
    input  logic                               finAck,
    output logic [$clog2(reqNumber+1)-1:0]     pendingCount,
    output logic                               err
);

    localparam int PW = $clog2(reqNumber + 1);

    if (reqNumber < 1 || reqNumber > 16) begin : g_bad_req_number
        $error("req_join_ctrl: reqNumber out of range 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("req_join_ctrl: TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FIRE    = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [reqNumber-1:0] captured_q, captured_d;
    logic [reqNumber-1:0] acks_q, acks_d;
    logic                 fin_q, fin_d;
    logic [PW-1:0]        pcount_q, pcount_d;
    logic                 err_q, err_d;
    logic                 tmo_hit;
    logic [reqNumber-1:0] merged;

`ifdef REQ_JOIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts only while a transaction is partially collected; completion wins over timeout.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (state_q == COLLECT && captured_q != '0 && !(&merged)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign merged = captured_q | reqs;

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        acks_d     = acks_q;
        fin_d      = fin_q;
        err_d      = 1'b0;
        case (state_q)
            COLLECT: begin
                captured_d = merged;
                acks_d     = '0;
                fin_d      = 1'b0;
                if (&merged) begin
                    state_d = FIRE;
                    fin_d   = 1'b1;
                end else if (tmo_hit) begin
                    // Abort: acknowledge whoever arrived, never fire.
                    state_d = DRAIN;
                    acks_d  = merged;
                    err_d   = 1'b1;
                end
            end
            FIRE: begin
                if (finAck) begin
                    state_d = DRAIN;
                    fin_d   = 1'b0;
                    acks_d  = '1;
                end
            end
            DRAIN: begin
                // AND-only update: a re-raised request cannot be re-captured here.
                captured_d = captured_q & reqs;
                acks_d     = acks_q & reqs;
                fin_d      = 1'b0;
                if (captured_d == '0 && !finAck) state_d = COLLECT;
            end
            default: begin
                state_d    = COLLECT;
                captured_d = '0;
                acks_d     = '0;
                fin_d      = 1'b0;
            end
        endcase
    end

    always_comb begin
        pcount_d = '0;
        for (int i = 0; i < reqNumber; i++) pcount_d = pcount_d + PW'(captured_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            captured_q <= '0;
            acks_q     <= '0;
            fin_q      <= 1'b0;
            pcount_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            acks_q     <= acks_d;
            fin_q      <= fin_d;
            pcount_q   <= pcount_d;
            err_q      <= err_d;
        end
    end

    assign acks         = acks_q;
    assign fin          = fin_q;
    assign pendingCount = pcount_q;
    assign err          = err_q;

endmodule

// File: tb/tb_req_join_ctrl.sv
// Directed self-checking bench for req_join_ctrl (reqNumber=3, TIMEOUT_CYCLES=4).
module tb_req_join_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] reqs;
    logic [2:0] acks;
    logic       fin;
    logic       finAck;
    logic [1:0] pendingCount;
    logic       err;

    int checks = 0;
    int errors = 0;

    req_join_ctrl #(.reqNumber(3), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .reqs(reqs), .acks(acks), .fin(fin),
        .finAck(finAck), .pendingCount(pendingCount), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_acks, input logic e_fin,
                             input logic [1:0] e_pc);
        check({tag, ".acks"}, 32'(acks), 32'(e_acks));
        check({tag, ".fin"},  32'(fin),  32'(e_fin));
        check({tag, ".pc"},   32'(pendingCount), 32'(e_pc));
    endtask

    initial begin
        rst = 1'b1; reqs = 3'b000; finAck = 1'b0;
        step(); step();
        check_all("reset", 3'b000, 1'b0, 2'd0);
        check("reset.err", 32'(err), 32'd0);
        rst = 1'b0;

        // Staggered collection 001 -> 011 -> 111
        reqs = 3'b001; step(); check_all("col1", 3'b000, 1'b0, 2'd1);
        reqs = 3'b011; step(); check_all("col2", 3'b000, 1'b0, 2'd2);
        reqs = 3'b111; step(); check_all("col3", 3'b000, 1'b1, 2'd3);

        // fin held while finAck low
        for (int i = 0; i < 5; i++) begin
            step(); check_all("fire_hold", 3'b000, 1'b1, 2'd3);
        end
        finAck = 1'b1; step(); check_all("fire_ack", 3'b111, 1'b0, 2'd3);
        finAck = 1'b0;

        // Drain: drop [1], then [0] with [1] re-raised, then [2]
        reqs = 3'b101; step(); check_all("drain1", 3'b101, 1'b0, 2'd2);
        reqs = 3'b110; step(); check_all("drain2", 3'b100, 1'b0, 2'd1);
        reqs = 3'b010; step(); check_all("drain3", 3'b000, 1'b0, 2'd0);
        // Back in COLLECT; reqs[1] sampled on the return edge was not captured
        step(); check_all("recollect", 3'b000, 1'b0, 2'd1);
        reqs = 3'b111; step(); check_all("recol_full", 3'b000, 1'b1, 2'd3);
        finAck = 1'b1; step(); check_all("recol_ack", 3'b111, 1'b0, 2'd3);
        finAck = 1'b0; reqs = 3'b000; step(); check_all("recol_drain", 3'b000, 1'b0, 2'd0);

        // finAck in COLLECT is ignored; captured bits are sticky
        finAck = 1'b1; reqs = 3'b001; step(); check_all("ackcol1", 3'b000, 1'b0, 2'd1);
        reqs = 3'b000; step(); check_all("ackcol2", 3'b000, 1'b0, 2'd1);
        finAck = 1'b0; reqs = 3'b110; step(); check_all("ackcol3", 3'b000, 1'b1, 2'd3);
        finAck = 1'b1; step(); check_all("ackcol4", 3'b111, 1'b0, 2'd3);
        // finAck still high: drain completes but COLLECT waits for finAck low
        reqs = 3'b000; step(); check_all("ackcol5", 3'b000, 1'b0, 2'd0);
        reqs = 3'b111; step(); check_all("ackcol6", 3'b000, 1'b0, 2'd0);
        finAck = 1'b0; reqs = 3'b000; step(); check_all("ackcol7", 3'b000, 1'b0, 2'd0);

        // Simultaneous arrival
        reqs = 3'b111; step(); check_all("simul", 3'b000, 1'b1, 2'd3);

        // Reset during FIRE with reqs held
        rst = 1'b1; step(); check_all("rst_fire", 3'b000, 1'b0, 2'd0);
        rst = 1'b0; step(); check_all("rst_recap", 3'b000, 1'b1, 2'd3);
        finAck = 1'b1; step(); check_all("rst_ack", 3'b111, 1'b0, 2'd3);
        finAck = 1'b0; reqs = 3'b000; step(); check_all("rst_drain", 3'b000, 1'b0, 2'd0);

        // Partial request held: timeout behaviour
        reqs = 3'b001; step(); check_all("tmo_start", 3'b000, 1'b0, 2'd1);
`ifdef REQ_JOIN_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(); check("tmo_wait.err", 32'(err), 32'd0);
        end
        step();
        check("tmo_hit.err", 32'(err), 32'd1);
        check_all("tmo_hit", 3'b001, 1'b0, 2'd1);
        step();
        check("tmo_after.err", 32'(err), 32'd0);
        check_all("tmo_after", 3'b001, 1'b0, 2'd1);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            check("notmo.err", 32'(err), 32'd0);
            check("notmo.fin", 32'(fin), 32'd0);
        end
        check_all("notmo_end", 3'b000, 1'b0, 2'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_join_ctrl.md
REQ_JOIN_CTRL -- requirements
Module: req_join_ctrl

Interface
REQ-001 Parameter reqNumber, default 3: number of requesters joined; legal range 1..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: COLLECT timeout in clk cycles; legal range 1..65535; used only with REQ_JOIN_TIMEOUT_EN.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port reqs, input, reqNumber: per-requester four-phase request levels.
REQ-006 Port acks, output, reqNumber: per-requester acknowledge levels, registered.
REQ-007 Port fin, output, 1: joined request to downstream, registered.
REQ-008 Port finAck, input, 1: downstream acknowledge for fin.
REQ-009 Port pendingCount, output, $clog2(reqNumber+1): number of set bits in the captured mask, registered.
REQ-010 Port err, output, 1: timeout abort pulse, registered.

Function
REQ-011 Internal state: captured mask (reqNumber bits) plus FSM with states COLLECT, FIRE, DRAIN.
REQ-012 COLLECT: each edge, captured <= captured | reqs; acks=0; fin=0.
REQ-013 COLLECT->FIRE on the edge where (captured | reqs) is all ones; fin is 1 in the first cycle after that edge, giving one-cycle latency from the completing request.
REQ-014 Requests arriving in the same cycle are captured together; no ordering between requesters.
REQ-015 FIRE: fin held at 1 until finAck is sampled 1; on that edge, fin<=0, acks<=all ones, and the state moves to DRAIN.
REQ-016 finAck sampled 1 in COLLECT is ignored.
REQ-017 DRAIN: on each edge, for every i with reqs[i]=0, captured[i]<=0 and acks[i]<=0; acks[i] stays 1 while reqs[i]=1.
REQ-018 DRAIN: a request that drops and re-rises is not re-captured until the state returns to COLLECT.
REQ-019 DRAIN->COLLECT on the edge where captured is all zero and finAck=0; new reqs sampled on that edge are not captured; capture resumes on the next edge.
REQ-020 pendingCount equals popcount(captured) as registered after each edge; its range is 0..reqNumber.
REQ-021 reqNumber=1: the join degenerates to a pass-through; fin rises one cycle after reqs[0] and the same handshake applies.

Reset
REQ-022 rst=1 sampled on an edge: state<=COLLECT, captured<=0, acks<=0, fin<=0, pendingCount<=0, err<=0, timeout counter<=0; this takes priority over all other events.
REQ-023 Reset asserted mid-handshake (FIRE or DRAIN) abandons the transaction with no fin and no acks after the edge; requesters still holding reqs high are recaptured from the first edge after rst=0.

Configuration
REQ-024 Macro REQ_JOIN_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) increments each COLLECT cycle in which captured is nonzero and not complete.
REQ-025 The counter clears on leaving COLLECT or when captured is zero.
REQ-026 When the counter reaches TIMEOUT_CYCLES: err=1 for exactly one cycle, acks<=captured, the state moves to DRAIN, and fin is never asserted for that transaction.
REQ-027 Macro REQ_JOIN_TIMEOUT_EN undefined: no counter exists, err is tied to 0, and COLLECT waits indefinitely; the port list is identical in both builds.

Verification
REQ-028 reqNumber=3, reqs 001 -> 011 -> 111 on consecutive edges -> pendingCount 1,2 then FIRE; fin=1 one cycle after the 111 edge; acks=000 throughout.
REQ-029 In FIRE, hold finAck=0 for 5 cycles then 1 -> fin stays 1 for 5 cycles; on the finAck edge fin=0 and acks=111.
REQ-030 In DRAIN, drop reqs[1] first, then [0], then [2], with finAck low -> acks go 101, 100, 000 on successive edges; COLLECT is reentered on the 000 edge; a re-raised reqs[1] during DRAIN is not counted.
REQ-031 All three reqs rise in the same cycle -> pendingCount 3 and fin on the next cycle.
REQ-032 rst pulse during FIRE with reqs=111 held -> fin=0 after the reset edge; pendingCount=3 and fin=1 return within 2 cycles of rst release.
REQ-033 With REQ_JOIN_TIMEOUT_EN, TIMEOUT_CYCLES=4, reqs=001 held -> err=1 for one cycle after 4 incomplete cycles; acks=001; fin never rises. Without the macro, the same stimulus gives err=0 for 100 cycles.
